// File: rtl/windowed_datapath_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | windowed_datapath_pkg : ALU opcodes, flag bit positions, MUL states   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package windowed_datapath_pkg;

   localparam logic [3:0] c_OP_PASSB = 4'd0;
   localparam logic [3:0] c_OP_AND   = 4'd1;
   localparam logic [3:0] c_OP_OR    = 4'd2;
   localparam logic [3:0] c_OP_NOTB  = 4'd3;
   localparam logic [3:0] c_OP_SHL   = 4'd4;
   localparam logic [3:0] c_OP_SHR   = 4'd5;
   localparam logic [3:0] c_OP_ADD   = 4'd6;
   localparam logic [3:0] c_OP_SUB   = 4'd7;
   localparam logic [3:0] c_OP_MUL   = 4'd8;
   localparam logic [3:0] c_OP_CMP   = 4'd9;

   localparam int c_FLAG_C = 0;
   localparam int c_FLAG_Z = 1;
   localparam int c_FLAG_N = 2;
   localparam int c_FLAG_V = 3;

   typedef enum logic [0:0] {
      MUL_IDLE = 1'b0,
      MUL_RUN  = 1'b1
   } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/windowed_datapath_p_seq_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_multiplier : W-cycle shift-add unsigned multiplier                |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module seq_multiplier
   import windowed_datapath_pkg::*;
#(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic           o_busy,
   output logic           o_done,
   output logic [2*W-1:0] o_product
);

   localparam int c_CW = $clog2(W);

   mul_state_t        r_state;
   logic [2*W-1:0]    r_mcand;
   logic [2*W-1:0]    r_acc;
   logic [W-1:0]      r_mplier;
   logic [c_CW-1:0]   r_count;

   logic [2*W-1:0]    w_acc_next;
   logic              w_last;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_last     = (r_state == MUL_RUN) && (r_count == c_CW'(W - 1));

   // o_done/o_product flag the edge on which the final partial sum lands,
   // so the consumer can capture the product on that same edge.
   assign o_busy    = (r_state == MUL_RUN);
   assign o_done    = w_last;
   assign o_product = w_acc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= MUL_IDLE;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            MUL_IDLE: begin
               if (i_start) begin
                  r_mcand  <= {{W{1'b0}}, i_a};
                  r_mplier <= i_b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_state  <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               r_acc    <= w_acc_next;
               r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[W-1:1]};
               r_count  <= r_count + 1'b1;
               if (w_last) begin
                  r_state <= MUL_IDLE;
               end
            end
            default: r_state <= MUL_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/windowed_datapath_p.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | windowed_datapath_p : windowed register file, address unit, IR, ALU   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module windowed_datapath_p
   import windowed_datapath_pkg::*;
#(
   parameter int          W        = 16,
   parameter int          NREG     = 64,
   parameter int unsigned PC_RESET = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] databus_in,
   output logic [W-1:0] databus_out,
   output logic [W-1:0] addressbus,
   output logic [W-1:0] instruction,
   input  logic         ir_load,
   input  logic         reset_pc,
   input  logic         pc_plus_i,
   input  logic         pc_plus_1,
   input  logic         r_plus_i,
   input  logic         r_plus_0,
   input  logic         rs_on_au,
   input  logic         rd_on_au,
   input  logic         enable_pc,
   input  logic [1:0]   l_sel,
   input  logic [1:0]   r_sel,
   input  logic         rf_lwrite,
   input  logic         rf_hwrite,
   input  logic         wp_reset,
   input  logic         wp_add,
   input  logic         addr_on_databus,
   input  logic         alu_on_databus,
   input  logic         ir_on_lopnd,
   input  logic         ir_on_hopnd,
   input  logic         rf_right_on_opnd,
   input  logic [3:0]   alu_op,
   input  logic         alu_start,
   output logic         alu_busy,
   output logic         alu_done,
   input  logic         cset,
   input  logic         creset,
   input  logic         zset,
   input  logic         zreset,
   output logic [3:0]   flags
);

   localparam int c_H   = W / 2;
   localparam int c_WPW = $clog2(NREG);

   logic [W-1:0]     r_regs [NREG];
   logic [W-1:0]     r_pc;
   logic [W-1:0]     r_ir;
   logic [c_WPW-1:0] r_wp;
   logic [W-1:0]     r_alu_result;
   logic [3:0]       r_flags;
   logic             r_done;
   logic             r_pend;
   logic [3:0]       r_op;
   logic [W-1:0]     r_op_a;
   logic [W-1:0]     r_op_b;

   logic [c_WPW-1:0] w_lidx;
   logic [c_WPW-1:0] w_ridx;
   logic [W-1:0]     w_left;
   logic [W-1:0]     w_right;
   logic [W-1:0]     w_imm;
   logic [W-1:0]     w_au_r;
   logic [W-1:0]     w_addr;
   logic [W-1:0]     w_wdata;
   logic [c_H-1:0]   w_b_lo;
   logic [c_H-1:0]   w_b_hi;
   logic [W-1:0]     w_opnd_b;
   logic             w_accept;
   logic             w_mul_start;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic [2*W-1:0]   w_product;
   logic [W:0]       w_sum;
   logic [W:0]       w_diff;
   logic [W-1:0]     w_alu_val;
   logic             w_alu_known;
   logic             w_alu_wres;
   logic             w_alu_c;
   logic             w_alu_v;

   assign w_lidx  = r_wp + c_WPW'(l_sel);
   assign w_ridx  = r_wp + c_WPW'(r_sel);
   assign w_left  = r_regs[w_lidx];
   assign w_right = r_regs[w_ridx];
   assign w_imm   = {{(W - c_H){r_ir[c_H-1]}}, r_ir[c_H-1:0]};

   always_comb begin
      w_au_r = '0;
      if (rs_on_au) begin
         w_au_r = w_right;
      end else if (rd_on_au) begin
         w_au_r = w_left;
      end

      w_addr = r_pc;
      if (reset_pc) begin
         w_addr = '0;
      end else if (pc_plus_i) begin
         w_addr = r_pc + w_imm;
      end else if (pc_plus_1) begin
         w_addr = r_pc + W'(1);
      end else if (r_plus_i) begin
         w_addr = w_au_r + w_imm;
      end else if (r_plus_0) begin
         w_addr = w_au_r;
      end
   end

   assign addressbus  = w_addr;
   assign instruction = r_ir;
   assign w_wdata     = addr_on_databus ? w_addr :
                        alu_on_databus  ? r_alu_result : databus_in;
   assign databus_out = addr_on_databus ? w_addr :
                        alu_on_databus  ? r_alu_result : '0;

   assign w_b_lo   = ir_on_lopnd      ? r_ir[c_H-1:0]   :
                     rf_right_on_opnd ? w_right[c_H-1:0] : '0;
   assign w_b_hi   = ir_on_hopnd      ? r_ir[c_H-1:0]   :
                     rf_right_on_opnd ? w_right[W-1:c_H] : '0;
   assign w_opnd_b = {w_b_hi, w_b_lo};

   // Register file is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (rf_lwrite) begin
         r_regs[w_lidx][c_H-1:0] <= w_wdata[c_H-1:0];
      end
      if (rf_hwrite) begin
         r_regs[w_lidx][W-1:c_H] <= w_wdata[W-1:c_H];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= W'(PC_RESET);
         r_ir <= '0;
         r_wp <= '0;
      end else begin
         if (enable_pc) begin
            r_pc <= w_addr;
         end
         if (ir_load) begin
            r_ir <= w_wdata;
         end
         if (wp_reset) begin
            r_wp <= '0;
         end else if (wp_add) begin
            r_wp <= r_wp + r_ir[c_WPW-1:0];
         end
      end
   end

   assign w_accept    = alu_start && !w_mul_busy;
   assign w_mul_start = w_accept && (alu_op == c_OP_MUL);

   seq_multiplier #(
      .W (W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (w_left),
      .i_b       (w_opnd_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   always_comb begin
      w_sum       = {1'b0, r_op_a} + {1'b0, r_op_b};
      w_diff      = {1'b0, r_op_a} - {1'b0, r_op_b};
      w_alu_val   = r_alu_result;
      w_alu_known = 1'b1;
      w_alu_wres  = 1'b1;
      w_alu_c     = r_flags[c_FLAG_C];
      w_alu_v     = r_flags[c_FLAG_V];
      case (r_op)
         c_OP_PASSB: w_alu_val = r_op_b;
         c_OP_AND:   w_alu_val = r_op_a & r_op_b;
         c_OP_OR:    w_alu_val = r_op_a | r_op_b;
         c_OP_NOTB:  w_alu_val = ~r_op_b;
         c_OP_SHL: begin
            w_alu_val = {r_op_a[W-2:0], 1'b0};
            w_alu_c   = r_op_a[W-1];
         end
         c_OP_SHR: begin
            w_alu_val = {1'b0, r_op_a[W-1:1]};
            w_alu_c   = r_op_a[0];
         end
         c_OP_ADD: begin
            w_alu_val = w_sum[W-1:0];
            w_alu_c   = w_sum[W];
            w_alu_v   = (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[W-1] != r_op_a[W-1]);
         end
         c_OP_SUB, c_OP_CMP: begin
            // CMP shares the subtractor; Z on the difference equals A == B.
            w_alu_val  = w_diff[W-1:0];
            w_alu_c    = w_diff[W];
            w_alu_v    = (r_op_a[W-1] != r_op_b[W-1]) && (w_diff[W-1] != r_op_a[W-1]);
            w_alu_wres = (r_op != c_OP_CMP);
         end
         default: w_alu_known = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend       <= 1'b0;
         r_op         <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_alu_result <= '0;
         r_flags      <= '0;
         r_done       <= 1'b0;
      end else begin
         r_pend <= w_accept && (alu_op != c_OP_MUL);
         if (w_accept) begin
            r_op   <= alu_op;
            r_op_a <= w_left;
            r_op_b <= w_opnd_b;
         end

         r_done <= 1'b0;
         if (w_mul_done) begin
            r_alu_result      <= w_product[W-1:0];
            r_flags[c_FLAG_C] <= |w_product[2*W-1:W];
            r_flags[c_FLAG_Z] <= (w_product[W-1:0] == '0);
            r_flags[c_FLAG_N] <= w_product[W-1];
            r_flags[c_FLAG_V] <= 1'b0;
            r_done            <= 1'b1;
         end else if (r_pend) begin
            r_done <= 1'b1;
            if (w_alu_known) begin
               if (w_alu_wres) begin
                  r_alu_result <= w_alu_val;
               end
               r_flags[c_FLAG_C] <= w_alu_c;
               r_flags[c_FLAG_Z] <= (w_alu_val == '0);
               r_flags[c_FLAG_N] <= w_alu_val[W-1];
               r_flags[c_FLAG_V] <= w_alu_v;
            end
         end

         // Direct flag strobes override the ALU; set beats reset.
         if (cset) begin
            r_flags[c_FLAG_C] <= 1'b1;
         end else if (creset) begin
            r_flags[c_FLAG_C] <= 1'b0;
         end
         if (zset) begin
            r_flags[c_FLAG_Z] <= 1'b1;
         end else if (zreset) begin
            r_flags[c_FLAG_Z] <= 1'b0;
         end
      end
   end

   assign alu_busy = w_mul_busy;
   assign alu_done = r_done;
   assign flags    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_windowed_datapath_p.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_windowed_datapath_p : scoreboard bench for windowed_datapath_p     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_windowed_datapath_p;
   import windowed_datapath_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] databus_in;
   logic [W-1:0] databus_out;
   logic [W-1:0] addressbus;
   logic [W-1:0] instruction;
   logic         ir_load, reset_pc, pc_plus_i, pc_plus_1, r_plus_i, r_plus_0;
   logic         rs_on_au, rd_on_au, enable_pc;
   logic [1:0]   l_sel, r_sel;
   logic         rf_lwrite, rf_hwrite, wp_reset, wp_add;
   logic         addr_on_databus, alu_on_databus;
   logic         ir_on_lopnd, ir_on_hopnd, rf_right_on_opnd;
   logic [3:0]   alu_op;
   logic         alu_start, alu_busy, alu_done;
   logic         cset, creset, zset, zreset;
   logic [3:0]   flags;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   fl;
      string        nm;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done   = 0;

   always #5 clk = ~clk;

   windowed_datapath_p #(
      .W (W), .NREG (64), .PC_RESET (0)
   ) dut (
      .clk (clk), .rst (rst),
      .databus_in (databus_in), .databus_out (databus_out),
      .addressbus (addressbus), .instruction (instruction),
      .ir_load (ir_load), .reset_pc (reset_pc), .pc_plus_i (pc_plus_i),
      .pc_plus_1 (pc_plus_1), .r_plus_i (r_plus_i), .r_plus_0 (r_plus_0),
      .rs_on_au (rs_on_au), .rd_on_au (rd_on_au), .enable_pc (enable_pc),
      .l_sel (l_sel), .r_sel (r_sel),
      .rf_lwrite (rf_lwrite), .rf_hwrite (rf_hwrite),
      .wp_reset (wp_reset), .wp_add (wp_add),
      .addr_on_databus (addr_on_databus), .alu_on_databus (alu_on_databus),
      .ir_on_lopnd (ir_on_lopnd), .ir_on_hopnd (ir_on_hopnd),
      .rf_right_on_opnd (rf_right_on_opnd),
      .alu_op (alu_op), .alu_start (alu_start),
      .alu_busy (alu_busy), .alu_done (alu_done),
      .cset (cset), .creset (creset), .zset (zset), .zreset (zreset),
      .flags (flags)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every alu_done pulse consumes one expected entry.
   always @(negedge clk) begin
      if (!rst && alu_done) begin
         n_done++;
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got alu_done=1, expected no pending op");
         end else begin
            m_e = q.pop_front();
            check({m_e.nm, "_result"}, databus_out, m_e.res);
            check({m_e.nm, "_flags"}, flags, m_e.fl);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      databus_in = '0; ir_load = 0; reset_pc = 0; pc_plus_i = 0; pc_plus_1 = 0;
      r_plus_i = 0; r_plus_0 = 0; rs_on_au = 0; rd_on_au = 0; enable_pc = 0;
      l_sel = 0; r_sel = 0; rf_lwrite = 0; rf_hwrite = 0; wp_reset = 0; wp_add = 0;
      addr_on_databus = 0; alu_on_databus = 1; ir_on_lopnd = 0; ir_on_hopnd = 0;
      rf_right_on_opnd = 0; alu_op = 0; alu_start = 0;
      cset = 0; creset = 0; zset = 0; zreset = 0;
   endtask

   task automatic rf_write(input logic [1:0] sel, input logic [W-1:0] v,
                           input logic lo, input logic hi);
      l_sel = sel; databus_in = v; alu_on_databus = 0;
      rf_lwrite = lo; rf_hwrite = hi;
      step();
      rf_lwrite = 0; rf_hwrite = 0; alu_on_databus = 1;
   endtask

   task automatic ir_write(input logic [W-1:0] v);
      databus_in = v; alu_on_databus = 0; ir_load = 1;
      step();
      ir_load = 0; alu_on_databus = 1;
   endtask

   task automatic alu_issue(input logic [3:0] op, input logic [1:0] ls, input logic [1:0] rs,
                            input logic ropnd, input logic irlo, input logic irhi);
      l_sel = ls; r_sel = rs; rf_right_on_opnd = ropnd;
      ir_on_lopnd = irlo; ir_on_hopnd = irhi; alu_op = op; alu_start = 1;
      step();
      alu_start = 0; rf_right_on_opnd = 0; ir_on_lopnd = 0; ir_on_hopnd = 0;
   endtask

   task automatic expect_op(input logic [W-1:0] res, input logic [3:0] fl, input string nm);
      exp_t e;
      e.res = res; e.fl = fl; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (q.size() != 0 && k < budget) begin
         step();
         k++;
      end
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got %0d pending ops, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic au_check(input string name, input logic [W-1:0] exp);
      #1;
      check(name, addressbus, exp);
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      idle();
      #2;
      check("rst_instruction", instruction, 16'h0000);
      check("rst_flags", flags, 4'h0);
      check("rst_busy", alu_busy, 1'b0);
      check("rst_done", alu_done, 1'b0);
      check("rst_addressbus", addressbus, 16'h0000);
      check("rst_alu_result", databus_out, 16'h0000);
      #10;
      rst = 1'b0;
      step();

      wp_reset = 1; step(); wp_reset = 0;
      rf_write(2'd0, 16'd300, 1, 1);
      rf_write(2'd1, 16'd200, 1, 1);
      rf_write(2'd2, 16'h7FFF, 1, 1);
      rf_write(2'd3, 16'h0100, 1, 1);

      // MUL 300 * 200
      expect_op(16'hEA60, 4'b0100, "mul_300x200");
      alu_issue(c_OP_MUL, 2'd0, 2'd1, 1, 0, 0);
      cnt = 0;
      while (alu_busy && cnt < 40) begin
         cnt++;
         step();
      end
      check("mul_busy_cycles", cnt, 16);
      wait_drain(8);

      // MUL 0x100 * 0x100 with a stray start mid-operation
      expect_op(16'h0000, 4'b0011, "mul_overflow");
      alu_issue(c_OP_MUL, 2'd3, 2'd3, 1, 0, 0);
      repeat (3) step();
      check("mul_busy_mid", alu_busy, 1'b1);
      alu_issue(c_OP_MUL, 2'd0, 2'd1, 1, 0, 0);
      wait_drain(30);
      repeat (20) step();

      // ADD 0x7FFF + IR-immediate 1
      ir_write(16'h0001);
      expect_op(16'h8000, 4'b1100, "add_ovf");
      alu_issue(c_OP_ADD, 2'd2, 2'd0, 0, 1, 0);
      wait_drain(8);
      cset = 1; creset = 1; step(); cset = 0; creset = 0;
      check("cset_wins", flags, 4'b1101);
      creset = 1; step(); creset = 0;
      check("creset", flags, 4'b1100);
      zset = 1; zreset = 1; step(); zset = 0; zreset = 0;
      check("zset_wins", flags, 4'b1110);
      zreset = 1; step(); zreset = 0;
      check("zreset", flags, 4'b1100);

      expect_op(16'h0064, 4'b0000, "sub_pos");
      alu_issue(c_OP_SUB, 2'd0, 2'd1, 1, 0, 0);
      wait_drain(8);
      expect_op(16'hFF9C, 4'b0101, "sub_borrow");
      alu_issue(c_OP_SUB, 2'd1, 2'd0, 1, 0, 0);
      wait_drain(8);
      expect_op(16'hFF9C, 4'b0010, "cmp_equal");
      alu_issue(c_OP_CMP, 2'd0, 2'd0, 1, 0, 0);
      wait_drain(8);
      expect_op(16'hFF9C, 4'b0010, "undef_op");
      alu_issue(4'hF, 2'd0, 2'd1, 1, 0, 0);
      wait_drain(8);
      expect_op(16'hFFFE, 4'b0100, "shl");
      alu_issue(c_OP_SHL, 2'd2, 2'd0, 0, 0, 0);
      wait_drain(8);
      expect_op(16'h0101, 4'b0000, "and_irboth");
      alu_issue(c_OP_AND, 2'd2, 2'd0, 0, 1, 1);
      wait_drain(8);

      // Window pointer wrap: 62 + 3 -> 1
      ir_write(16'h003E);
      wp_add = 1; step(); wp_add = 0;
      l_sel = 2'd3; rd_on_au = 1; r_plus_0 = 1;
      au_check("wrap_read_old", 16'h00C8);
      rd_on_au = 0; r_plus_0 = 0;
      rf_write(2'd3, 16'hBEEF, 1, 1);
      l_sel = 2'd3; rd_on_au = 1; r_plus_0 = 1;
      au_check("wrap_write_read", 16'hBEEF);
      rd_on_au = 0; r_plus_0 = 0;
      ir_write(16'h0003);
      wp_add = 1; step(); wp_add = 0;
      l_sel = 2'd0; rd_on_au = 1; r_plus_0 = 1;
      au_check("wp_after_add", 16'hBEEF);
      rd_on_au = 0; r_plus_0 = 0;
      r_sel = 2'd0; rs_on_au = 1; r_plus_i = 1;
      au_check("r_plus_i", 16'hBEF2);
      rs_on_au = 0; r_plus_i = 0;
      wp_reset = 1; step(); wp_reset = 0;
      rf_write(2'd1, 16'h1234, 1, 0);
      l_sel = 2'd1; rd_on_au = 1; r_plus_0 = 1;
      au_check("low_half_write", 16'hBE34);
      rd_on_au = 0; r_plus_0 = 0;
      rf_write(2'd1, 16'hAB00, 0, 1);
      l_sel = 2'd1; rd_on_au = 1; r_plus_0 = 1;
      au_check("high_half_write", 16'hAB34);
      rd_on_au = 0; r_plus_0 = 0;

      // PC relative with negative immediate
      ir_write(16'h0010);
      pc_plus_i = 1; enable_pc = 1; step(); pc_plus_i = 0; enable_pc = 0;
      au_check("pc_0x10", 16'h0010);
      ir_write(16'h00FE);
      check("instruction", instruction, 16'h00FE);
      pc_plus_i = 1;
      au_check("pc_plus_neg2", 16'h000E);
      enable_pc = 1; step(); pc_plus_i = 0; enable_pc = 0;
      au_check("pc_0x0e", 16'h000E);
      pc_plus_1 = 1;
      au_check("pc_plus_1", 16'h000F);
      reset_pc = 1;
      au_check("reset_pc_wins", 16'h0000);
      pc_plus_1 = 0; reset_pc = 0;
      addr_on_databus = 1;
      #1;
      check("addr_on_databus", databus_out, 16'h000E);
      addr_on_databus = 0;

      // Reset during MUL cycle 5
      alu_issue(c_OP_MUL, 2'd0, 2'd0, 1, 0, 0);
      repeat (4) step();
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", alu_busy, 1'b0);
      check("abort_done", alu_done, 1'b0);
      check("abort_result", databus_out, 16'h0000);
      check("abort_flags", flags, 4'h0);
      check("abort_instruction", instruction, 16'h0000);
      check("abort_pc", addressbus, 16'h0000);
      @(negedge clk);
      #2;
      rst = 1'b0;
      repeat (24) step();
      check("abort_result_later", databus_out, 16'h0000);
      check("abort_busy_later", alu_busy, 1'b0);

      check("done_count", n_done, 9);
      check("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
